// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded control, operands and register
// addresses, inserts a one-cycle bubble on load-use hazards and counts them.
module id_ex_stage #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              ex_hold,
   input  logic              id_valid,
   input  logic [3:0]        id_mem_signals,
   input  logic [5:0]        id_ex_signals,
   input  logic [2:0]        id_wb_signals,
   input  logic [REG_AW-1:0] id_rs_addr,
   input  logic [REG_AW-1:0] id_rt_addr,
   input  logic [REG_AW-1:0] id_rd_addr,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   output logic              stall_upstream,
   output logic              ex_valid,
   output logic [3:0]        ex_mem_signals,
   output logic [5:0]        ex_ex_signals,
   output logic [2:0]        ex_wb_signals,
   output logic [REG_AW-1:0] ex_rs_addr,
   output logic [REG_AW-1:0] ex_rt_addr,
   output logic [REG_AW-1:0] ex_rd_addr,
   output logic [DATA_W-1:0] ex_rs_data,
   output logic [DATA_W-1:0] ex_rt_data,
   output logic [DATA_W-1:0] ex_imm,
   output logic [CNT_W-1:0]  hazard_cnt
);

   localparam logic [3:0] MEM_BUBBLE = 4'b0000;
   localparam logic [5:0] EX_BUBBLE  = 6'b000000;
   localparam logic [2:0] WB_BUBBLE  = 3'b011;

   logic              r_valid_p1;
   logic [3:0]        r_mem_p1;
   logic [5:0]        r_ex_p1;
   logic [2:0]        r_wb_p1;
   logic [REG_AW-1:0] r_rs_addr_p1;
   logic [REG_AW-1:0] r_rt_addr_p1;
   logic [REG_AW-1:0] r_rd_addr_p1;
   logic [DATA_W-1:0] r_rs_data_p1;
   logic [DATA_W-1:0] r_rt_data_p1;
   logic [DATA_W-1:0] r_imm_p1;
   logic [CNT_W-1:0]  r_hazard_cnt;

   logic w_load_use;
   logic w_bubble;
   logic w_count;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   // A load in EX whose destination is read by the instruction in ID.
   assign w_load_use = r_valid_p1 & r_mem_p1[3] & r_wb_p1[2] & id_valid &
                       ((id_uses_rs & (id_rs_addr == r_rd_addr_p1)) |
                        (id_uses_rt & (id_rt_addr == r_rd_addr_p1)));

   assign stall_upstream = ex_hold | (w_load_use & ~flush);
   assign w_bubble       = rst | flush | (~ex_hold & w_load_use);
   assign w_count        = ~flush & ~ex_hold & w_load_use;

   // ---- ID -> EX boundary ----
   always_ff @(posedge clk) begin
      if (w_bubble) begin
         r_valid_p1   <= 1'b0;
         r_mem_p1     <= MEM_BUBBLE;
         r_ex_p1      <= EX_BUBBLE;
         r_wb_p1      <= WB_BUBBLE;
         r_rs_addr_p1 <= '0;
         r_rt_addr_p1 <= '0;
         r_rd_addr_p1 <= '0;
         r_rs_data_p1 <= '0;
         r_rt_data_p1 <= '0;
         r_imm_p1     <= '0;
      end else if (!ex_hold) begin
         r_valid_p1   <= id_valid;
         r_mem_p1     <= id_valid ? id_mem_signals : MEM_BUBBLE;
         r_ex_p1      <= id_valid ? id_ex_signals  : EX_BUBBLE;
         r_wb_p1      <= id_valid ? id_wb_signals  : WB_BUBBLE;
         r_rs_addr_p1 <= id_rs_addr;
         r_rt_addr_p1 <= id_rt_addr;
         r_rd_addr_p1 <= id_rd_addr;
         r_rs_data_p1 <= id_rs_data;
         r_rt_data_p1 <= id_rt_data;
         r_imm_p1     <= id_imm;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_hazard_cnt <= '0;
      else if (w_count)
         r_hazard_cnt <= sat_inc(r_hazard_cnt);
   end

   assign ex_valid       = r_valid_p1;
   assign ex_mem_signals = r_mem_p1;
   assign ex_ex_signals  = r_ex_p1;
   assign ex_wb_signals  = r_wb_p1;
   assign ex_rs_addr     = r_rs_addr_p1;
   assign ex_rt_addr     = r_rt_addr_p1;
   assign ex_rd_addr     = r_rd_addr_p1;
   assign ex_rs_data     = r_rs_data_p1;
   assign ex_rt_data     = r_rt_data_p1;
   assign ex_imm         = r_imm_p1;
   assign hazard_cnt     = r_hazard_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, counter saturation run and
// randomized traffic compared against a rule-level model of the stage.
module tb_id_ex_stage;

   localparam int DW  = 16;
   localparam int AW  = 3;
   localparam int CW  = 8;
   localparam int CMAX = (1 << CW) - 1;

   typedef struct packed {
      logic          valid;
      logic [3:0]    mem;
      logic [5:0]    ex;
      logic [2:0]    wb;
      logic [AW-1:0] rs;
      logic [AW-1:0] rt;
      logic [AW-1:0] rd;
      logic          urs;
      logic          urt;
      logic [DW-1:0] rsd;
      logic [DW-1:0] rtd;
      logic [DW-1:0] imm;
   } ins_t;

   typedef struct {
      bit         rst, flush, hold;
      ins_t       in;
      bit         e_stall, e_valid;
      logic [3:0] e_mem;
      logic [2:0] e_wb;
      logic [15:0] e_rsd;
      logic [7:0] e_cnt;
   } row_t;

   logic          clk = 1'b0;
   logic          rst, flush, ex_hold, id_valid;
   logic [3:0]    id_mem_signals;
   logic [5:0]    id_ex_signals;
   logic [2:0]    id_wb_signals;
   logic [AW-1:0] id_rs_addr, id_rt_addr, id_rd_addr;
   logic          id_uses_rs, id_uses_rt;
   logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
   logic          stall_upstream, ex_valid;
   logic [3:0]    ex_mem_signals;
   logic [5:0]    ex_ex_signals;
   logic [2:0]    ex_wb_signals;
   logic [AW-1:0] ex_rs_addr, ex_rt_addr, ex_rd_addr;
   logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm;
   logic [CW-1:0] hazard_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   ins_t m_st;
   int   m_cnt;

   always #5 clk = ~clk;

   id_ex_stage #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .flush(flush), .ex_hold(ex_hold), .id_valid(id_valid),
      .id_mem_signals(id_mem_signals), .id_ex_signals(id_ex_signals),
      .id_wb_signals(id_wb_signals), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
      .id_rd_addr(id_rd_addr), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .stall_upstream(stall_upstream), .ex_valid(ex_valid),
      .ex_mem_signals(ex_mem_signals), .ex_ex_signals(ex_ex_signals),
      .ex_wb_signals(ex_wb_signals), .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr),
      .ex_rd_addr(ex_rd_addr), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
      .ex_imm(ex_imm), .hazard_cnt(hazard_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic ins_t bubble();
      ins_t b;
      b = '0;
      b.wb = 3'b011;
      return b;
   endfunction

   function automatic ins_t mk(input logic v, input logic [3:0] mem, input logic [5:0] ex,
                               input logic [2:0] wb, input int rs, input int rt, input int rd,
                               input logic urs, input logic urt, input logic [15:0] rsd);
      ins_t i;
      i.valid = v; i.mem = mem; i.ex = ex; i.wb = wb;
      i.rs = AW'(rs); i.rt = AW'(rt); i.rd = AW'(rd);
      i.urs = urs; i.urt = urt;
      i.rsd = rsd; i.rtd = rsd ^ 16'h00F0; i.imm = rsd + 16'd1;
      return i;
   endfunction

   function automatic row_t row(input bit r, input bit f, input bit h, input ins_t in,
                                input bit es, input bit ev, input logic [3:0] em,
                                input logic [2:0] ew, input logic [15:0] ed, input int ec);
      row_t t;
      t.rst = r; t.flush = f; t.hold = h; t.in = in;
      t.e_stall = es; t.e_valid = ev; t.e_mem = em; t.e_wb = ew; t.e_rsd = ed;
      t.e_cnt = 8'(ec);
      return t;
   endfunction

   // Load-use: the instruction in EX is a valid load writing a register that
   // the incoming valid instruction actually reads.
   function automatic bit model_lu(input ins_t in);
      bit hit_rs, hit_rt;
      hit_rs = in.urs && (in.rs == m_st.rd);
      hit_rt = in.urt && (in.rt == m_st.rd);
      return m_st.valid && m_st.mem[3] && m_st.wb[2] && in.valid && (hit_rs || hit_rt);
   endfunction

   task automatic model_edge(input bit r, input bit f, input bit h, input ins_t in);
      bit lu;
      lu = model_lu(in);
      if (r) begin
         m_st = bubble();
         m_cnt = 0;
      end else if (f) begin
         m_st = bubble();
      end else if (h) begin
         m_st = m_st;
      end else if (lu) begin
         m_st = bubble();
         m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
      end else begin
         m_st = in;
         m_st.urs = 1'b0;
         m_st.urt = 1'b0;
         if (!in.valid) begin
            m_st.mem = 4'b0000;
            m_st.ex  = 6'b000000;
            m_st.wb  = 3'b011;
         end
      end
   endtask

   task automatic drive(input bit r, input bit f, input bit h, input ins_t in);
      rst = r; flush = f; ex_hold = h;
      id_valid = in.valid; id_mem_signals = in.mem; id_ex_signals = in.ex;
      id_wb_signals = in.wb; id_rs_addr = in.rs; id_rt_addr = in.rt; id_rd_addr = in.rd;
      id_uses_rs = in.urs; id_uses_rt = in.urt;
      id_rs_data = in.rsd; id_rt_data = in.rtd; id_imm = in.imm;
   endtask

   // One clock: check the combinational stall against the model before the
   // edge, advance the model at the edge, then check every registered output.
   task automatic step(input bit r, input bit f, input bit h, input ins_t in, output logic s);
      bit exp_s;
      drive(r, f, h, in);
      #1;
      s = stall_upstream;
      exp_s = h || (model_lu(in) && !f);
      chk("stall_upstream", s, exp_s);
      @(posedge clk);
      model_edge(r, f, h, in);
      #1;
      chk("ex_valid", ex_valid, m_st.valid);
      chk("ex_mem", ex_mem_signals, m_st.mem);
      chk("ex_ex", ex_ex_signals, m_st.ex);
      chk("ex_wb", ex_wb_signals, m_st.wb);
      chk("ex_rs_addr", ex_rs_addr, m_st.rs);
      chk("ex_rt_addr", ex_rt_addr, m_st.rt);
      chk("ex_rd_addr", ex_rd_addr, m_st.rd);
      chk("ex_rs_data", ex_rs_data, m_st.rsd);
      chk("ex_rt_data", ex_rt_data, m_st.rtd);
      chk("ex_imm", ex_imm, m_st.imm);
      chk("hazard_cnt", hazard_cnt, m_cnt);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      row_t tbl[22];
      ins_t ADD, LDD, ADD4, ADD4N, INV, LDD0, ADD0, ri;
      logic s;
      logic [31:0] rv;

      ADD   = mk(1, 4'b0000, 6'b001010, 3'b101, 1, 2, 3, 1, 1, 16'h0005);
      LDD   = mk(1, 4'b1000, 6'b000011, 3'b100, 1, 0, 4, 1, 0, 16'h0007);
      ADD4  = mk(1, 4'b0000, 6'b001010, 3'b101, 4, 2, 5, 1, 1, 16'h0009);
      ADD4N = mk(1, 4'b0000, 6'b001010, 3'b101, 4, 2, 5, 0, 1, 16'h0009);
      INV   = mk(0, 4'b1000, 6'b000011, 3'b100, 1, 0, 4, 1, 0, 16'h0007);
      LDD0  = mk(1, 4'b1000, 6'b000011, 3'b100, 1, 0, 0, 1, 0, 16'h0007);
      ADD0  = mk(1, 4'b0000, 6'b001010, 3'b101, 3, 0, 6, 1, 1, 16'h0011);

      //            rst f h  in     stall vld mem      wb      rs_data  cnt
      tbl[0]  = row(1, 0, 0, ADD,   0, 0, 4'b0000, 3'b011, 16'h0000, 0);
      tbl[1]  = row(0, 0, 0, ADD,   0, 1, 4'b0000, 3'b101, 16'h0005, 0);
      tbl[2]  = row(0, 0, 0, LDD,   0, 1, 4'b1000, 3'b100, 16'h0007, 0);
      tbl[3]  = row(0, 0, 0, ADD4,  1, 0, 4'b0000, 3'b011, 16'h0000, 1);
      tbl[4]  = row(0, 0, 0, ADD4,  0, 1, 4'b0000, 3'b101, 16'h0009, 1);
      tbl[5]  = row(0, 0, 0, LDD,   0, 1, 4'b1000, 3'b100, 16'h0007, 1);
      tbl[6]  = row(0, 0, 0, ADD4N, 0, 1, 4'b0000, 3'b101, 16'h0009, 1);
      tbl[7]  = row(0, 0, 0, LDD,   0, 1, 4'b1000, 3'b100, 16'h0007, 1);
      tbl[8]  = row(0, 0, 1, ADD4,  1, 1, 4'b1000, 3'b100, 16'h0007, 1);
      tbl[9]  = row(0, 0, 1, ADD,   1, 1, 4'b1000, 3'b100, 16'h0007, 1);
      tbl[10] = row(0, 0, 1, ADD4,  1, 1, 4'b1000, 3'b100, 16'h0007, 1);
      tbl[11] = row(0, 0, 0, ADD,   0, 1, 4'b0000, 3'b101, 16'h0005, 1);
      tbl[12] = row(0, 0, 0, LDD,   0, 1, 4'b1000, 3'b100, 16'h0007, 1);
      tbl[13] = row(0, 1, 0, ADD4,  0, 0, 4'b0000, 3'b011, 16'h0000, 1);
      tbl[14] = row(0, 0, 0, LDD,   0, 1, 4'b1000, 3'b100, 16'h0007, 1);
      tbl[15] = row(0, 1, 1, ADD,   1, 0, 4'b0000, 3'b011, 16'h0000, 1);
      tbl[16] = row(0, 0, 0, INV,   0, 0, 4'b0000, 3'b011, 16'h0007, 1);
      tbl[17] = row(0, 0, 0, LDD,   0, 1, 4'b1000, 3'b100, 16'h0007, 1);
      tbl[18] = row(1, 0, 0, ADD4,  1, 0, 4'b0000, 3'b011, 16'h0000, 0);
      tbl[19] = row(0, 0, 0, LDD0,  0, 1, 4'b1000, 3'b100, 16'h0007, 0);
      tbl[20] = row(0, 0, 0, ADD0,  1, 0, 4'b0000, 3'b011, 16'h0000, 1);
      tbl[21] = row(0, 0, 0, ADD0,  0, 1, 4'b0000, 3'b101, 16'h0011, 1);

      // Initial reset; registers are unknown before it so nothing is checked.
      drive(1, 0, 0, bubble());
      m_st = bubble();
      m_cnt = 0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 22; i++) begin
         step(tbl[i].rst, tbl[i].flush, tbl[i].hold, tbl[i].in, s);
         chk($sformatf("vec%0d stall", i), s, tbl[i].e_stall);
         chk($sformatf("vec%0d valid", i), ex_valid, tbl[i].e_valid);
         chk($sformatf("vec%0d mem", i), ex_mem_signals, tbl[i].e_mem);
         chk($sformatf("vec%0d wb", i), ex_wb_signals, tbl[i].e_wb);
         chk($sformatf("vec%0d rs_data", i), ex_rs_data, tbl[i].e_rsd);
         chk($sformatf("vec%0d cnt", i), hazard_cnt, tbl[i].e_cnt);
      end

      // Counter saturation: drive the load-use pattern past all-ones.
      step(1, 0, 0, ADD, s);
      for (int i = 0; i < CMAX + 2; i++) begin
         step(0, 0, 0, LDD, s);
         step(0, 0, 0, ADD4, s);
      end
      chk("sat hazard_cnt", hazard_cnt, CMAX);
      step(0, 0, 0, LDD, s);
      step(1, 0, 1, ADD4, s);
      chk("post-rst cnt", hazard_cnt, 0);
      chk("post-rst valid", ex_valid, 1'b0);
      chk("post-rst wb", ex_wb_signals, 3'b011);
      chk("post-rst mem", ex_mem_signals, 4'b0000);
      chk("post-rst ex", ex_ex_signals, 6'b000000);
      chk("post-rst rd", ex_rd_addr, 0);
      chk("post-rst imm", ex_imm, 0);

      // Randomized traffic with a small register range to provoke hazards.
      for (int i = 0; i < 800; i++) begin
         rv = $urandom;
         ri.valid = (rv[1:0] != 2'b00);
         ri.mem   = {rv[2], rv[5:3]};
         ri.ex    = rv[11:6];
         ri.wb    = {rv[12] | rv[13], rv[15:14]};
         ri.rs    = {1'b0, rv[17:16]};
         ri.rt    = {1'b0, rv[19:18]};
         ri.rd    = {1'b0, rv[21:20]};
         ri.urs   = rv[22];
         ri.urt   = rv[23];
         rv = $urandom;
         ri.rsd   = rv[15:0];
         ri.rtd   = rv[31:16];
         rv = $urandom;
         ri.imm   = rv[15:0];
         step(rv[31:26] == 6'd0, rv[25:23] == 3'd0, rv[22:20] == 3'd0, ri, s);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage of the five-stage processor. Captures the decoded control bundles (MEM/EX/WB signals from the control unit), operand data, immediate and register addresses each cycle. Detects load-use hazards against the instruction it currently holds and inserts a one-cycle bubble. Also supports an external hold from downstream, a flush for control-flow redirects, and keeps a saturating count of hazard bubbles.

## Interface
- DATA_W, 16, operand/immediate width
- REG_AW, 3, register address width (8 registers)
- CNT_W, 16, hazard-bubble counter width

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard the incoming instruction; load a bubble
- ex_hold  in  1  downstream busy; freeze all stage registers
- id_valid  in  1  decode slot holds a real instruction
- id_mem_signals  in  4  {memRead, memWrite, memAddress, memData}
- id_ex_signals  in  6  {ALUop[3:0], ALU_en, shamSel}
- id_wb_signals  in  3  {regWrite, WBsel[1:0]}
- id_rs_addr, id_rt_addr, id_rd_addr  in  REG_AW  source/source/destination registers
- id_uses_rs, id_uses_rt  in  1  instruction actually reads that source
- id_rs_data, id_rt_data, id_imm  in  DATA_W  operands and immediate
- stall_upstream  out  1  combinational; PC and IF/ID must hold this cycle
- ex_valid  out  1  registered valid
- ex_mem_signals, ex_ex_signals, ex_wb_signals  out  4/6/3  registered control bundles
- ex_rs_addr, ex_rt_addr, ex_rd_addr  out  REG_AW  registered addresses
- ex_rs_data, ex_rt_data, ex_imm  out  DATA_W  registered data
- hazard_cnt  out  CNT_W  number of load-use bubbles inserted

## Operation
- The bubble value is: valid 0, mem 4'b0000, ex 6'b000000, wb 3'b011 (regWrite 0, WBsel "none"), and all addresses and data 0.
- load_use = ex_valid & ex_mem_signals[3] & ex_wb_signals[2] & id_valid & ((id_uses_rs & id_rs_addr==ex_rd_addr) | (id_uses_rt & id_rt_addr==ex_rd_addr)).
- stall_upstream = ex_hold | (load_use & ~flush).
- The per-edge update uses this priority, highest first:
  1. rst: load the bubble; hazard_cnt = 0.
  2. flush: load the bubble. This applies even when ex_hold is 1. hazard_cnt is unchanged.
  3. ex_hold: all ex_* registers hold their values. hazard_cnt is unchanged.
  4. load_use: load the bubble; hazard_cnt increments and saturates at all-ones. Upstream holds, so the same ID instruction is presented again next cycle.
  5. Otherwise: capture all id_* inputs; ex_valid = id_valid.
- When id_valid is 0 and no other event applies, the inputs are captured as-is. Control bits are still forced to the bubble encoding, so an invalid slot can never assert memRead, memWrite or regWrite.
- Because a bubble clears memRead, a load-use stall lasts exactly one cycle per offending load. The re-presented instruction then passes on the following cycle.
- Register address 0 gets no special treatment: matching on address 0 stalls like any other address.

## Timing
- All ex_* outputs and hazard_cnt are registered; latency from id_* to ex_* is 1 cycle.
- stall_upstream is combinational from the current ex_* registers and the id_* inputs, with no registered delay. It must be stable before the clock edge.
- Reset values: ex_valid 0, ex_mem_signals 0000, ex_ex_signals 000000, ex_wb_signals 011, all addresses and data 0, hazard_cnt 0. stall_upstream follows its equation, so it is 0 after reset unless ex_hold is 1.
- rst asserted mid-hold or mid-stall clears the stage on that edge. No pending hazard survives reset.
- With ex_hold held for N cycles, the stage outputs are identical for N+1 observations, and no bubble is counted.
- With flush and load_use in the same cycle: a bubble is loaded, the counter is not incremented, and stall_upstream is 0 unless ex_hold is 1.

## Test plan
- Reset, then ADD (mem 0000, ex 001010, wb 101, rs=1, rt=2, rd=3, rs_data 0x0005) -> after 1 edge: ex_valid 1, ex_wb 101, ex_rs_data 0x0005; stall_upstream 0 throughout.
- LDD rd=4 (mem 1000, wb 100), followed by ADD using rs=4 -> stall_upstream 1 for exactly one cycle; ex shows a bubble (wb 011, valid 0); the next edge captures the ADD; hazard_cnt = 1.
- LDD rd=4, followed by an instruction with rs=4 but id_uses_rs=0 -> no stall; hazard_cnt = 0.
- ex_hold=1 for 3 cycles while id inputs change -> ex_* frozen at their prior values; stall_upstream 1; on release the current id value is captured.
- Load-use together with flush=1 -> bubble loaded, stall_upstream 0, hazard_cnt unchanged. Separately, flush=1 together with ex_hold=1 -> bubble loaded despite the hold.
- Preset hazard_cnt near 0xFFFF by repeating the load-use pattern, then add 2 more hazards -> count stays at 0xFFFF. Assert rst -> hazard_cnt 0 and all outputs at their reset values on the next edge.
